control_sequencer: RTL and testbench
====================================

# control_sequencer

Parametrised multi-cycle control sequencer for the datapath CPU. It is the next-generation replacement for the fixed 5-bit-opcode control FSM. It decodes the instruction register into per-class microsequences and drives a single one-hot-field control word into the datapath. Over the previous generation it adds:
- generic register-file size;
- memory wait-state handshaking;
- conditional branch commit;
- illegal-opcode trapping;
- instruction-boundary Stop.

## Interface
Parameters:
- DATA_W, 32, instruction/datapath width
- OPCODE_W, 5, opcode field width, located at IR[DATA_W-1 -: OPCODE_W]
- NUM_REGS, 16, register count; Reg_enableIn width
- LINK_REG, 15, register index written by JAL

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- IR  in  DATA_W  current instruction register contents
- Stop  in  1  halt request, sampled synchronously
- mem_ready  in  1  memory has completed the current read/write
- con_ff  in  1  branch condition flip-flop from the datapath
- ctrl  out  CTRL_W  control word; bit positions are defined in the package
- Reg_enableIn  out  NUM_REGS  direct register write strobes (JAL link only)
- Run  out  1  high while executing
- illegal_op  out  1  high while in TRAP
- state  out  8  current state code, for debug

## Operation
- Moore machine. All outputs are a pure decode of the registered state; no delays appear in RTL.
- **Reset:**
  - While Reset=0, state=RESET, ctrl=0, Reg_enableIn=0, illegal_op=0, Run=1.
  - Reset mid-instruction abandons the instruction immediately.
- **Fetch:**
  - FETCH0: PCout, MARin.
  - FETCH1: MDRin, MDR_read, IncPC, PCin. Holds while mem_ready=0.
  - FETCH2: MDRout, IRin. Decodes IR opcode to a class via the package table.
- **Execute classes and states:**
  - ALU (add/sub/and/or/shl/shr/rol/ror): A3 Grb·Rout·Yin; A4 Grc·Rout·ZHighIn·ZLowIn; A5 ZLowout·Gra·Rin.
  - IMM (addi/andi/ori/ldi): I3 Grb·Rout·Yin (BAout for ldi); I4 Cout·ZHighIn·ZLowIn; I5 ZLowout·Gra·Rin.
  - MD (mul/div): M3, M4 as ALU; M5 ZLowout·LOin; M6 ZHighout·HIin.
  - UN (neg/not): U3 Grb·Rout·ZHighIn·ZLowIn; U4 ZLowout·Gra·Rin.
  - LD: L3 Grb·BAout·Yin; L4 Cout·Z*In; L5 ZLowout·MARin; L6 MDR_read·MDRin, holds until mem_ready; L7 MDRout·Gra·Rin.
  - ST: S3–S5 as LD; S6 Gra·Rout·MDRin; S7 MDRout·RAM_write, holds until mem_ready.
  - BR: B3 Grb·Rout·CONin; B4 PCout·Yin; B5 Cout·Z*In; B6 ZLowout, with PCin only if con_ff=1.
  - JR: J3 Gra·Rout·PCin.
  - JAL: K3 PCout, Reg_enableIn[LINK_REG]=1; K4 Gra·Rout·PCin.
  - Single-cycle states: MFHI3 HIout·Gra·Rin; MFLO3 LOout·Gra·Rin; IN3 InPortout·Gra·Rin; OUT3 Gra·Rout·OutPortin; NOP3 nothing.
- **Completion:** the final state of every class returns to FETCH0.
- **Stop:**
  - Sampled only on the FETCH0 transition, i.e. at an instruction boundary.
  - Stop=1 there → HALT instead of FETCH0.
  - HALT: Run=0, ctrl=0. Sticky until Reset.
- **Illegal opcode** (unmapped or compiled-out): FETCH2 → TRAP. TRAP: illegal_op=1, Run=0, ctrl=0. Sticky until Reset.
- **HALT opcode:** FETCH2 → HALT.

## Timing
- RESET → FETCH0 on the first edge after Reset deasserts.
- Each state lasts one cycle except FETCH1, L6 and S7, which extend by one cycle per cycle mem_ready=0.
- With zero wait, instruction latency including fetch:
  - ALU/IMM: 6 cycles
  - MD: 7 cycles
  - UN: 5 cycles
  - LD/ST: 8 cycles
  - BR: 7 cycles
  - JAL: 5 cycles
  - JR/MFHI/MFLO/IN/OUT/NOP: 4 cycles
- mem_ready is sampled at the edge leaving the wait state. mem_ready=1 on entry gives no extra cycle.
- Stop asserted during a wait state is still honoured at the next boundary.

## Configuration
- CTRL_MUL_DIV_EN defined: MD class states exist; the mul/div opcodes execute.
- CTRL_MUL_DIV_EN undefined: MD states are removed; the mul/div opcodes decode as illegal → TRAP.

## Structure
- Package ctrl_pkg holds:
  - ctrl bit-index localparams and CTRL_W;
  - state encoding (8-bit);
  - opcode constants;
  - instruction class enum.
- Sub-module ctrl_decode: combinational opcode→class mapping, including the illegal flag and the CTRL_MUL_DIV_EN gating. The FSM and output decode live in the top.

## Test plan
- add, mem_ready tied 1 → FETCH0…A5 in 6 cycles; ctrl at A5 is exactly ZLowout|Gra|Rin; then FETCH0.
- ld with mem_ready low for 3 cycles in L6 → L6 lasts 4 cycles, MDRin held throughout; total latency 11 cycles.
- br with con_ff=0 → B6 asserts ZLowout without PCin. With con_ff=1 → PCin asserted for 1 cycle.
- jal with LINK_REG=15 → Reg_enableIn=16'h8000 for exactly the K3 cycle, 0 otherwise.
- Opcode 5'b11111 → TRAP after FETCH2; illegal_op=1, Run=0. Reset low mid-TRAP → RESET, all outputs cleared, Run=1.
- Stop pulsed during a mul, in M4 → mul completes through M6, then HALT with Run=0. Without CTRL_MUL_DIV_EN, mul → TRAP.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-word bits, state codes, opcodes and classes.
// CTRL_MUL_DIV_EN adds the MD state block.
package ctrl_pkg;

  localparam int C_PCOUT  = 0;
  localparam int C_MARIN  = 1;
  localparam int C_MDRIN  = 2;
  localparam int C_MDRRD  = 3;
  localparam int C_INCPC  = 4;
  localparam int C_PCIN   = 5;
  localparam int C_MDROUT = 6;
  localparam int C_IRIN   = 7;
  localparam int C_GRA    = 8;
  localparam int C_GRB    = 9;
  localparam int C_GRC    = 10;
  localparam int C_ROUT   = 11;
  localparam int C_RIN    = 12;
  localparam int C_BAOUT  = 13;
  localparam int C_YIN    = 14;
  localparam int C_ZHIN   = 15;
  localparam int C_ZLIN   = 16;
  localparam int C_ZLOUT  = 17;
  localparam int C_ZHOUT  = 18;
  localparam int C_COUT   = 19;
  localparam int C_LOIN   = 20;
  localparam int C_HIIN   = 21;
  localparam int C_LOOUT  = 22;
  localparam int C_HIOUT  = 23;
  localparam int C_CONIN  = 24;
  localparam int C_RAMWR  = 25;
  localparam int C_INPOUT = 26;
  localparam int C_OUTPIN = 27;
  localparam int CTRL_W   = 28;

  typedef logic [CTRL_W-1:0] ctrl_t;

  function automatic ctrl_t cb(input int i);
    return ctrl_t'(1) << i;
  endfunction

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  typedef enum logic [4:0] {
    CL_ALU, CL_IMM, CL_LDI, CL_MD, CL_UN,
    CL_LD, CL_ST, CL_BR, CL_JR, CL_JAL,
    CL_MFHI, CL_MFLO, CL_IN, CL_OUT,
    CL_NOP, CL_HALT, CL_ILL
  } class_e;

  typedef enum logic [7:0] {
    S_RESET  = 8'h00,
    S_FETCH0 = 8'h01,
    S_FETCH1 = 8'h02,
    S_FETCH2 = 8'h03,
    S_A3 = 8'h10, S_A4, S_A5,
    S_I3 = 8'h18, S_I3L, S_I4, S_I5,
`ifdef CTRL_MUL_DIV_EN
    S_M3 = 8'h20, S_M4, S_M5, S_M6,
`endif
    S_U3 = 8'h28, S_U4,
    S_L3 = 8'h30, S_L4, S_L5, S_L6, S_L7,
    S_S3 = 8'h38, S_S4, S_S5, S_S6, S_S7,
    S_B3 = 8'h40, S_B4, S_B5, S_B6,
    S_J3 = 8'h48,
    S_K3 = 8'h50, S_K4,
    S_MFHI3 = 8'h58,
    S_MFLO3 = 8'h59,
    S_IN3   = 8'h5A,
    S_OUT3  = 8'h5B,
    S_NOP3  = 8'h5C,
    S_HALT  = 8'hF0,
    S_TRAP  = 8'hFF
  } state_e;

endpackage

// File: rtl/control_sequencer_decode.sv
// ctrl_decode: opcode to instruction class, with illegal flag.
// mul/div map to CL_MD only when CTRL_MUL_DIV_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output class_e              o_class,
  output logic                o_illegal
);

  logic [4:0] w_op;
  logic       w_hi;

  assign w_op = i_opcode[4:0];
  // opcodes wider than the table are illegal if the extra bits are set
  assign w_hi = |(i_opcode >> 5);

  always_comb begin
    o_class = CL_ILL;
    case (w_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR:
        o_class = CL_ALU;
      OP_ADDI, OP_ANDI, OP_ORI:
        o_class = CL_IMM;
      OP_LDI:  o_class = CL_LDI;
`ifdef CTRL_MUL_DIV_EN
      OP_MUL, OP_DIV:
        o_class = CL_MD;
`endif
      OP_NEG, OP_NOT:
        o_class = CL_UN;
      OP_LD:   o_class = CL_LD;
      OP_ST:   o_class = CL_ST;
      OP_BR:   o_class = CL_BR;
      OP_JR:   o_class = CL_JR;
      OP_JAL:  o_class = CL_JAL;
      OP_MFHI: o_class = CL_MFHI;
      OP_MFLO: o_class = CL_MFLO;
      OP_IN:   o_class = CL_IN;
      OP_OUT:  o_class = CL_OUT;
      OP_NOP:  o_class = CL_NOP;
      OP_HALT: o_class = CL_HALT;
      default: o_class = CL_ILL;
    endcase
    if (w_hi) o_class = CL_ILL;
  end

  assign o_illegal = (o_class == CL_ILL);

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore control FSM for the datapath CPU.
// CTRL_MUL_DIV_EN enables the mul/div microsequence.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5,
  parameter int NUM_REGS = 16,
  parameter int LINK_REG = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   IR,
  input  logic                Stop,
  input  logic                mem_ready,
  input  logic                con_ff,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [NUM_REGS-1:0] Reg_enableIn,
  output logic                Run,
  output logic                illegal_op,
  output logic [7:0]          state
);

  state_e r_state;
  state_e w_next;
  logic   r_stop_req;
  logic   w_fin;
  logic   w_stop;
  class_e w_class;
  logic   w_illegal;
  logic   w_unused;

  assign w_unused = ^IR[DATA_W-OPCODE_W-1:0];

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .i_opcode  (IR[DATA_W-1 -: OPCODE_W]),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  // a Stop seen mid-instruction waits for the next boundary
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_RESET;
      r_stop_req <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_stop_req <= r_stop_req | Stop;
    end
  end

  assign w_stop = Stop | r_stop_req;

  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    case (r_state)
      S_RESET:  w_next = S_FETCH0;
      S_FETCH0: w_next = S_FETCH1;
      S_FETCH1: if (mem_ready) w_next = S_FETCH2;
      S_FETCH2: begin
        if (w_illegal) w_next = S_TRAP;
        else begin
          case (w_class)
            CL_ALU:  w_next = S_A3;
            CL_IMM:  w_next = S_I3;
            CL_LDI:  w_next = S_I3L;
`ifdef CTRL_MUL_DIV_EN
            CL_MD:   w_next = S_M3;
`endif
            CL_UN:   w_next = S_U3;
            CL_LD:   w_next = S_L3;
            CL_ST:   w_next = S_S3;
            CL_BR:   w_next = S_B3;
            CL_JR:   w_next = S_J3;
            CL_JAL:  w_next = S_K3;
            CL_MFHI: w_next = S_MFHI3;
            CL_MFLO: w_next = S_MFLO3;
            CL_IN:   w_next = S_IN3;
            CL_OUT:  w_next = S_OUT3;
            CL_NOP:  w_next = S_NOP3;
            CL_HALT: w_next = S_HALT;
            default: w_next = S_TRAP;
          endcase
        end
      end
      S_A3:  w_next = S_A4;
      S_A4:  w_next = S_A5;
      S_I3,
      S_I3L: w_next = S_I4;
      S_I4:  w_next = S_I5;
`ifdef CTRL_MUL_DIV_EN
      S_M3:  w_next = S_M4;
      S_M4:  w_next = S_M5;
      S_M5:  w_next = S_M6;
      S_M6:  w_fin  = 1'b1;
`endif
      S_U3:  w_next = S_U4;
      S_L3:  w_next = S_L4;
      S_L4:  w_next = S_L5;
      S_L5:  w_next = S_L6;
      S_L6:  if (mem_ready) w_next = S_L7;
      S_S3:  w_next = S_S4;
      S_S4:  w_next = S_S5;
      S_S5:  w_next = S_S6;
      S_S6:  w_next = S_S7;
      S_S7:  w_fin  = mem_ready;
      S_B3:  w_next = S_B4;
      S_B4:  w_next = S_B5;
      S_B5:  w_next = S_B6;
      S_K3:  w_next = S_K4;
      S_A5, S_I5, S_U4, S_L7, S_B6,
      S_J3, S_K4, S_MFHI3, S_MFLO3,
      S_IN3, S_OUT3, S_NOP3:
        w_fin = 1'b1;
      S_HALT: w_next = S_HALT;
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
    if (w_fin) w_next = w_stop ? S_HALT : S_FETCH0;
  end

  always_comb begin
    ctrl         = '0;
    Reg_enableIn = '0;
    Run          = 1'b1;
    illegal_op   = 1'b0;
    case (r_state)
      S_FETCH0: ctrl = cb(C_PCOUT) | cb(C_MARIN);
      S_FETCH1: ctrl = cb(C_MDRIN) | cb(C_MDRRD)
                     | cb(C_INCPC) | cb(C_PCIN);
      S_FETCH2: ctrl = cb(C_MDROUT) | cb(C_IRIN);
      S_A3, S_I3:
        ctrl = cb(C_GRB) | cb(C_ROUT) | cb(C_YIN);
      S_I3L, S_L3, S_S3:
        ctrl = cb(C_GRB) | cb(C_BAOUT) | cb(C_YIN);
      S_A4:
        ctrl = cb(C_GRC) | cb(C_ROUT)
             | cb(C_ZHIN) | cb(C_ZLIN);
      S_I4, S_L4, S_S4, S_B5:
        ctrl = cb(C_COUT) | cb(C_ZHIN) | cb(C_ZLIN);
      S_A5, S_I5, S_U4:
        ctrl = cb(C_ZLOUT) | cb(C_GRA) | cb(C_RIN);
`ifdef CTRL_MUL_DIV_EN
      S_M3: ctrl = cb(C_GRB) | cb(C_ROUT) | cb(C_YIN);
      S_M4: ctrl = cb(C_GRC) | cb(C_ROUT)
                 | cb(C_ZHIN) | cb(C_ZLIN);
      S_M5: ctrl = cb(C_ZLOUT) | cb(C_LOIN);
      S_M6: ctrl = cb(C_ZHOUT) | cb(C_HIIN);
`endif
      S_U3:
        ctrl = cb(C_GRB) | cb(C_ROUT)
             | cb(C_ZHIN) | cb(C_ZLIN);
      S_L5, S_S5: ctrl = cb(C_ZLOUT) | cb(C_MARIN);
      S_L6: ctrl = cb(C_MDRRD) | cb(C_MDRIN);
      S_L7: ctrl = cb(C_MDROUT) | cb(C_GRA) | cb(C_RIN);
      S_S6: ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_MDRIN);
      S_S7: ctrl = cb(C_MDROUT) | cb(C_RAMWR);
      S_B3: ctrl = cb(C_GRB) | cb(C_ROUT) | cb(C_CONIN);
      S_B4: ctrl = cb(C_PCOUT) | cb(C_YIN);
      S_B6: ctrl = cb(C_ZLOUT) | (con_ff ? cb(C_PCIN) : '0);
      S_J3, S_K4:
        ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_PCIN);
      S_K3: begin
        ctrl = cb(C_PCOUT);
        Reg_enableIn[LINK_REG] = 1'b1;
      end
      S_MFHI3: ctrl = cb(C_HIOUT) | cb(C_GRA) | cb(C_RIN);
      S_MFLO3: ctrl = cb(C_LOOUT) | cb(C_GRA) | cb(C_RIN);
      S_IN3:   ctrl = cb(C_INPOUT) | cb(C_GRA) | cb(C_RIN);
      S_OUT3:  ctrl = cb(C_GRA) | cb(C_ROUT) | cb(C_OUTPIN);
      S_HALT:  Run = 1'b0;
      S_TRAP: begin
        Run        = 1'b0;
        illegal_op = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of the control sequencer.
// Build with or without CTRL_MUL_DIV_EN.
module tb_control_sequencer;
  import ctrl_pkg::*;

  logic              Clock;
  logic              Reset;
  logic [31:0]       IR;
  logic              Stop;
  logic              mem_ready;
  logic              con_ff;
  logic [CTRL_W-1:0] ctrl;
  logic [15:0]       Reg_enableIn;
  logic              Run;
  logic              illegal_op;
  logic [7:0]        state;

  int n_chk = 0;
  int n_err = 0;

  control_sequencer #(
    .DATA_W(32), .OPCODE_W(5),
    .NUM_REGS(16), .LINK_REG(15)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .IR           (IR),
    .Stop         (Stop),
    .mem_ready    (mem_ready),
    .con_ff       (con_ff),
    .ctrl         (ctrl),
    .Reg_enableIn (Reg_enableIn),
    .Run          (Run),
    .illegal_op   (illegal_op),
    .state        (state)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic load(input logic [4:0] op);
    IR = {op, 27'h0};
  endtask

  // run one instruction from FETCH0; count cycles to the next boundary
  task automatic lat(input string tag, input logic [4:0] op,
                     input int exp);
    int n;
    n = 0;
    load(op);
    do begin
      step();
      n++;
    end while (state != S_FETCH0 && state != S_HALT
               && state != S_TRAP && n < 64);
    check(tag, 64'(n), 64'(exp));
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Stop  = 1'b0;
    step(2);
    Reset = 1'b1;
    step();
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    IR = '0;
    Stop = 1'b0;
    mem_ready = 1'b1;
    con_ff = 1'b0;
    #1 Reset = 1'b0;
    step();
    check("rst_state", 64'(state), 64'(S_RESET));
    check("rst_ctrl", 64'(ctrl), 64'(0));
    check("rst_regen", 64'(Reg_enableIn), 64'(0));
    check("rst_ill", 64'(illegal_op), 64'(0));
    check("rst_run", 64'(Run), 64'(1));
    Reset = 1'b1;
    step();
    check("f0_state", 64'(state), 64'(S_FETCH0));
    check("f0_ctrl", 64'(ctrl),
          64'(cb(C_PCOUT) | cb(C_MARIN)));

    load(OP_ADD);
    step(5);
    check("add_a5", 64'(state), 64'(S_A5));
    check("add_a5_ctrl", 64'(ctrl),
          64'(cb(C_ZLOUT) | cb(C_GRA) | cb(C_RIN)));
    step();
    check("add_ret", 64'(state), 64'(S_FETCH0));

    lat("lat_sub", OP_SUB, 6);
    lat("lat_addi", OP_ADDI, 6);
    lat("lat_ldi", OP_LDI, 6);
    lat("lat_neg", OP_NEG, 5);
    lat("lat_jr", OP_JR, 4);
    lat("lat_mfhi", OP_MFHI, 4);
    lat("lat_out", OP_OUT, 4);
    lat("lat_nop", OP_NOP, 4);
    lat("lat_st", OP_ST, 8);
    lat("lat_ld", OP_LD, 8);
    lat("lat_br", OP_BR, 7);

    load(OP_NOP);
    mem_ready = 1'b0;
    step();
    check("f1_ctrl", 64'(ctrl), 64'(cb(C_MDRIN) | cb(C_MDRRD)
          | cb(C_INCPC) | cb(C_PCIN)));
    step();
    check("f1_hold", 64'(state), 64'(S_FETCH1));
    mem_ready = 1'b1;
    step(3);
    check("f1_wait_ret", 64'(state), 64'(S_FETCH0));

    load(OP_LD);
    n = 6;
    step(6);
    check("ld_l6", 64'(state), 64'(S_L6));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n++;
      check("ld_l6_hold", 64'(state), 64'(S_L6));
      check("ld_l6_ctrl", 64'(ctrl),
            64'(cb(C_MDRRD) | cb(C_MDRIN)));
    end
    mem_ready = 1'b1;
    step();
    n++;
    check("ld_l7", 64'(state), 64'(S_L7));
    step();
    n++;
    check("ld_ret", 64'(state), 64'(S_FETCH0));
    check("ld_lat", 64'(n), 64'(11));

    load(OP_BR);
    con_ff = 1'b0;
    step(6);
    check("br0_b6", 64'(state), 64'(S_B6));
    check("br0_ctrl", 64'(ctrl), 64'(cb(C_ZLOUT)));
    step();
    con_ff = 1'b1;
    step(6);
    check("br1_ctrl", 64'(ctrl),
          64'(cb(C_ZLOUT) | cb(C_PCIN)));
    step();
    check("br1_after", 64'(ctrl),
          64'(cb(C_PCOUT) | cb(C_MARIN)));
    con_ff = 1'b0;

    load(OP_JAL);
    check("jal_f0_re", 64'(Reg_enableIn), 64'(0));
    step(3);
    check("jal_k3", 64'(state), 64'(S_K3));
    check("jal_k3_re", 64'(Reg_enableIn), 64'(16'h8000));
    check("jal_k3_ctrl", 64'(ctrl), 64'(cb(C_PCOUT)));
    step();
    check("jal_k4_re", 64'(Reg_enableIn), 64'(0));
    check("jal_k4_ctrl", 64'(ctrl),
          64'(cb(C_GRA) | cb(C_ROUT) | cb(C_PCIN)));
    step();
    check("jal_ret", 64'(state), 64'(S_FETCH0));

    load(OP_MUL);
`ifdef CTRL_MUL_DIV_EN
    step(4);
    check("mul_m4", 64'(state), 64'(S_M4));
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    check("mul_m5", 64'(state), 64'(S_M5));
    step();
    check("mul_m6_ctrl", 64'(ctrl),
          64'(cb(C_ZHOUT) | cb(C_HIIN)));
    step();
    check("mul_halt", 64'(state), 64'(S_HALT));
    check("halt_run", 64'(Run), 64'(0));
    check("halt_ctrl", 64'(ctrl), 64'(0));
    step(2);
    check("halt_sticky", 64'(state), 64'(S_HALT));
`else
    step(3);
    check("mul_trap", 64'(state), 64'(S_TRAP));
    check("mul_ill", 64'(illegal_op), 64'(1));
`endif
    do_reset();
    check("rst2_f0", 64'(state), 64'(S_FETCH0));

    load(OP_HALT);
    step(3);
    check("hop_halt", 64'(state), 64'(S_HALT));
    check("hop_ill", 64'(illegal_op), 64'(0));
    do_reset();

    load(5'b11111);
    step(3);
    check("trap_state", 64'(state), 64'(S_TRAP));
    check("trap_ill", 64'(illegal_op), 64'(1));
    check("trap_run", 64'(Run), 64'(0));
    check("trap_ctrl", 64'(ctrl), 64'(0));
    step(2);
    check("trap_sticky", 64'(state), 64'(S_TRAP));
    Reset = 1'b0;
    #1;
    check("trst_state", 64'(state), 64'(S_RESET));
    check("trst_ill", 64'(illegal_op), 64'(0));
    check("trst_run", 64'(Run), 64'(1));
    check("trst_ctrl", 64'(ctrl), 64'(0));
    check("trst_re", 64'(Reg_enableIn), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
